// File: rtl/adc_sched_pkg.sv
// Shared types and defaults for the ADC channel scheduler.
package adc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, WAIT_LO, WAIT_HI, READ, FIN
    } state_t;

    localparam int DEF_CLK_DIV     = 16;
    localparam int DEF_EOC_TIMEOUT = 200;

    // Width of a requester index; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Free-running divider producing the converter clock and a one-cycle tick
// on the last clk8m cycle of every converter clock period.
module adc_clk_div #(
    parameter int CLK_DIV = 16
) (
    input  logic clk8m,
    input  logic rst,
    output logic adc_clk,
    output logic tick
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] r_div;

    always_ff @(posedge clk8m or posedge rst) begin
        if (rst)                            r_div <= '0;
        else if (r_div == DW'(CLK_DIV - 1)) r_div <= '0;
        else                                r_div <= r_div + 1'b1;
    end

    assign adc_clk = (r_div >= DW'(CLK_DIV / 2));
    assign tick    = (r_div == DW'(CLK_DIV - 1));

endmodule

// File: rtl/adc_channel_scheduler.sv
// Round-robin arbiter in front of one ADC0809-style converter; runs the
// address/ALE/START/EOC/OE sequence for the granted requester's channel.
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int EOC_TIMEOUT = DEF_EOC_TIMEOUT
) (
    input  logic               clk8m,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] req_ch,
    output logic [N_REQ-1:0]   grant,
    output logic               done,
    output logic               timeout_err,
    output logic [7:0]         rdata,
    output logic               busy,
    output logic               adc_clk,
    output logic [2:0]         ADDR,
    output logic               ALE,
    output logic               START,
    output logic               OE,
    input  logic               EOC,
    input  logic [7:0]         DATA
);

    localparam int PW = ptr_w(N_REQ);
    localparam int TW = $clog2(EOC_TIMEOUT + 1);

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_idx;
    logic [TW-1:0] r_tmo;
    logic          r_abort;
    logic          r_eoc_m;
    logic          r_eoc_s;
    logic          w_tick;
    logic          w_found;
    logic [PW-1:0] w_pick;

    adc_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk8m   (clk8m),
        .rst     (rst),
        .adc_clk (adc_clk),
        .tick    (w_tick)
    );

    // Scan downward so the last hit is the first set bit at or after base.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] rq,
                                            input logic [PW-1:0]    base);
        logic [PW:0] res;
        int          j;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(base) + k) % N_REQ;
            if (rq[j]) res = {1'b1, PW'(j)};
        end
        return res;
    endfunction

    assign {w_found, w_pick} = rr_pick(req, r_ptr);

    always_ff @(posedge clk8m or posedge rst) begin
        if (rst) begin
            r_eoc_m <= 1'b0;
            r_eoc_s <= 1'b0;
        end else begin
            r_eoc_m <= EOC;
            r_eoc_s <= r_eoc_m;
        end
    end

    always_ff @(posedge clk8m or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_abort     <= 1'b0;
            grant       <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
            ADDR        <= '0;
            ALE         <= 1'b0;
            START       <= 1'b0;
            OE          <= 1'b0;
        end else begin
            // busy stays up through the done cycle, then drops with it.
            if (done) begin
                done        <= 1'b0;
                timeout_err <= 1'b0;
                busy        <= 1'b0;
            end
            if (w_tick) begin
                case (r_state)
                    IDLE: if (w_found) begin
                        r_idx   <= w_pick;
                        ADDR    <= req_ch[3*int'(w_pick) +: 3];
                        grant   <= N_REQ'(1) << w_pick;
                        busy    <= 1'b1;
                        r_state <= SETUP;
                    end
                    SETUP: begin
                        ALE     <= 1'b1;
                        START   <= 1'b1;
                        r_state <= PULSE;
                    end
                    PULSE: begin
                        ALE     <= 1'b0;
                        START   <= 1'b0;
                        r_tmo   <= '0;
                        r_abort <= 1'b0;
                        r_state <= WAIT_LO;
                    end
                    WAIT_LO, WAIT_HI: begin
                        if (r_tmo == TW'(EOC_TIMEOUT - 1)) begin
                            r_abort <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                            if (r_state == WAIT_LO && !r_eoc_s) begin
                                r_state <= WAIT_HI;
                            end else if (r_state == WAIT_HI && r_eoc_s) begin
                                OE      <= 1'b1;
                                r_state <= READ;
                            end
                        end
                    end
                    READ: begin
                        rdata   <= DATA;
                        OE      <= 1'b0;
                        r_state <= FIN;
                    end
                    FIN: begin
                        done        <= 1'b1;
                        timeout_err <= r_abort;
                        grant       <= '0;
                        r_ptr       <= (r_idx == PW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Randomized bench for adc_channel_scheduler with a behavioural converter
// model and a round-robin reference.
module tb_adc_channel_scheduler;

    localparam int N = 4;

    logic           clk8m = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [3*N-1:0] req_ch;
    logic [N-1:0]   grant;
    logic           done, timeout_err, busy, adc_clk, ALE, START, OE, EOC;
    logic [7:0]     rdata, DATA;
    logic [2:0]     ADDR;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] adc_val [8];
    bit         stuck  = 1'b0;
    int         m_ptr  = 0;

    always #5 clk8m = ~clk8m;

    adc_channel_scheduler #(.N_REQ(N), .CLK_DIV(16), .EOC_TIMEOUT(200)) dut (
        .clk8m(clk8m), .rst(rst), .req(req), .req_ch(req_ch), .grant(grant),
        .done(done), .timeout_err(timeout_err), .rdata(rdata), .busy(busy),
        .adc_clk(adc_clk), .ADDR(ADDR), .ALE(ALE), .START(START), .OE(OE),
        .EOC(EOC), .DATA(DATA)
    );

    // Converter: EOC drops shortly after START, rises ~8 ADC clocks later.
    initial begin
        EOC  = 1'b1;
        DATA = 8'h00;
        forever begin
            @(posedge START);
            @(negedge START);
            if (!stuck) begin
                repeat (4) @(posedge clk8m);
                EOC = 1'b0;
                repeat (128) @(posedge clk8m);
                DATA = adc_val[ADDR];
                EOC  = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk8m);
        #1;
    endtask

    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Follows one transaction and reports what it saw.
    task automatic observe(input bit clr, output int gi, output logic [2:0] addr,
                           output int ale_w, output int start_w, output int oe_w,
                           output int done_w, output logic tmo, output logic [7:0] rd,
                           output bit held, output bit ok);
        logic [N-1:0] g;
        int           n;
        bit           seen;
        gi = -1; addr = 0; ale_w = 0; start_w = 0; oe_w = 0; done_w = 0;
        tmo = 0; rd = 0; held = 1; ok = 0; seen = 0; n = 0;
        while (!busy && n < 2000) begin step(); n++; end
        if (!busy) return;
        g    = grant;
        addr = ADDR;
        for (int i = 0; i < N; i++) if (g == (N'(1) << i)) gi = i;
        if (clr) req = '0;
        n = 0;
        while (n < 6000) begin
            ale_w   += int'(ALE);
            start_w += int'(START);
            oe_w    += int'(OE);
            if (done) begin
                done_w++;
                tmo  = tmo | timeout_err;
                seen = 1;
            end else begin
                if (seen) break;
                if (grant !== g) held = 0;
            end
            step();
            n++;
        end
        rd = rdata;
        ok = seen;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_ch = '0;
        repeat (3) step();
        checks++; if (grant !== 0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
        checks++; if ({done, timeout_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {done, timeout_err, busy}); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if ({adc_clk, ALE, START, OE, ADDR} !== 7'b0) begin errors++; $display("FAIL reset_adc_pins got=%b exp=0", {adc_clk, ALE, START, OE, ADDR}); end
        rst = 1'b0;
    endtask

    task automatic test_divider();
        int highs = 0, last_rise = -1, period = -1, ctl = 0;
        logic prev;
        prev = adc_clk;
        for (int i = 0; i < 160; i++) begin
            step();
            highs += int'(adc_clk);
            ctl   += int'(ALE | START | OE | busy);
            if (adc_clk && !prev) begin
                if (last_rise >= 0) period = i - last_rise;
                last_rise = i;
            end
            prev = adc_clk;
        end
        checks++; if (highs != 80) begin errors++; $display("FAIL div_high got=%0d exp=80", highs); end
        checks++; if (period != 16) begin errors++; $display("FAIL div_period got=%0d exp=16", period); end
        checks++; if (ctl != 0) begin errors++; $display("FAIL div_idle_ctl got=%0d exp=0", ctl); end
    endtask

    task automatic test_single();
        int gi, aw, sw, ow, dw; logic [2:0] a; logic t; logic [7:0] rd; bit h, ok;
        adc_val[5] = 8'hA7;
        req_ch = '0; req_ch[2:0] = 3'd5;
        req = 4'b0001;
        observe(1'b1, gi, a, aw, sw, ow, dw, t, rd, h, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done got=none exp=done"); end
        checks++; if (gi != 0 || !h) begin errors++; $display("FAIL single_grant got=%0d held=%0d exp=0", gi, h); end
        checks++; if (a !== 3'd5) begin errors++; $display("FAIL single_addr got=%0d exp=5", a); end
        checks++; if (aw != 16 || sw != 16) begin errors++; $display("FAIL single_ale_start got=%0d/%0d exp=16/16", aw, sw); end
        checks++; if (ow != 16) begin errors++; $display("FAIL single_oe got=%0d exp=16", ow); end
        checks++; if (dw != 1 || t !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%0d tmo=%b exp=1 tmo=0", dw, t); end
        checks++; if (rd !== 8'hA7) begin errors++; $display("FAIL single_rdata got=%h exp=a7", rd); end
        m_ptr = 1;
    endtask

    task automatic test_contention();
        int gi, aw, sw, ow, dw, exp; logic [2:0] a; logic t; logic [7:0] rd; bit h, ok;
        logic [2:0] ch [2];
        ch[0] = 3'($urandom); ch[1] = 3'($urandom);
        req_ch = '0; req_ch[2:0] = ch[0]; req_ch[5:3] = ch[1];
        req = 4'b0011;
        for (int it = 0; it < 4; it++) begin
            exp = rr_model(4'b0011, m_ptr);
            observe(it == 3, gi, a, aw, sw, ow, dw, t, rd, h, ok);
            checks++; if (gi != exp || !h) begin errors++; $display("FAIL cont_grant[%0d] got=%0d exp=%0d", it, gi, exp); end
            checks++; if (a !== ch[exp]) begin errors++; $display("FAIL cont_addr[%0d] got=%0d exp=%0d", it, a, ch[exp]); end
            checks++; if (!ok || dw != 1 || t !== 1'b0) begin errors++; $display("FAIL cont_done[%0d] got=%0d tmo=%b exp=1 tmo=0", it, dw, t); end
            checks++; if (rd !== adc_val[ch[exp]]) begin errors++; $display("FAIL cont_rdata[%0d] got=%h exp=%h", it, rd, adc_val[ch[exp]]); end
            m_ptr = (exp + 1) % N;
        end
    endtask

    task automatic test_stuck();
        int gi, aw, sw, ow, dw, r; logic [2:0] a; logic t; logic [7:0] rd, prev; bit h, ok;
        prev  = rdata;
        r     = $urandom_range(0, N - 1);
        stuck = 1'b1;
        req_ch = 12'($urandom);
        req = N'(1) << r;
        observe(1'b1, gi, a, aw, sw, ow, dw, t, rd, h, ok);
        checks++; if (!ok || dw != 1) begin errors++; $display("FAIL stuck_done got=%0d exp=1", dw); end
        checks++; if (t !== 1'b1) begin errors++; $display("FAIL stuck_timeout got=%b exp=1", t); end
        checks++; if (ow != 0 || rd !== prev) begin errors++; $display("FAIL stuck_oe_rdata got=%0d/%h exp=0/%h", ow, rd, prev); end
        checks++; if (gi != r || grant !== 0 || busy !== 1'b0) begin errors++; $display("FAIL stuck_idle got=%0d/%b/%b exp=%0d/0/0", gi, grant, busy, r); end
        stuck = 1'b0;
        m_ptr = (r + 1) % N;
    endtask

    task automatic test_dropped();
        int gi, aw, sw, ow, dw, n; logic [2:0] a, c; logic t; logic [7:0] rd; bit h, ok;
        c = 3'($urandom);
        req_ch = '0; req_ch[8:6] = c;
        req = 4'b0100;
        n = 0;
        while (EOC !== 1'b0 && n < 2000) begin step(); n++; end
        repeat (40) step();
        req = '0;
        observe(1'b0, gi, a, aw, sw, ow, dw, t, rd, h, ok);
        checks++; if (!ok || dw != 1) begin errors++; $display("FAIL drop_done got=%0d exp=1", dw); end
        checks++; if (gi != 2 || grant !== 0) begin errors++; $display("FAIL drop_grant got=%0d/%b exp=2/0", gi, grant); end
        checks++; if (rd !== adc_val[c] || t !== 1'b0) begin errors++; $display("FAIL drop_rdata got=%h tmo=%b exp=%h tmo=0", rd, t, adc_val[c]); end
        m_ptr = 3;
    endtask

    task automatic test_reset_mid();
        int gi, aw, sw, ow, dw, n, dones, exp; logic [2:0] a; logic t; logic [7:0] rd; bit h, ok;
        req_ch = 12'($urandom);
        req = 4'b0010;
        n = 0;
        while (EOC !== 1'b0 && n < 2000) begin step(); n++; end
        repeat (40) step();
        #2 rst = 1'b1;
        #1;
        checks++; if ({grant, busy, ALE, START, OE, done, ADDR, rdata} !== '0) begin errors++; $display("FAIL rstmid_outputs got=%b exp=0", {grant, busy, ALE, START, OE, done, ADDR, rdata}); end
        req = '0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin step(); dones += int'(done); end
        rst = 1'b0;
        for (int i = 0; i < 250; i++) begin step(); dones += int'(done); end
        checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
        m_ptr = 0;
        req_ch = 12'($urandom);
        req = 4'b1010;
        exp = rr_model(4'b1010, m_ptr);
        observe(1'b1, gi, a, aw, sw, ow, dw, t, rd, h, ok);
        checks++; if (gi != exp || a !== req_ch[3*exp +: 3]) begin errors++; $display("FAIL rstmid_next got=%0d ch%0d exp=%0d ch%0d", gi, a, exp, req_ch[3*exp +: 3]); end
        checks++; if (!ok || rd !== adc_val[req_ch[3*exp +: 3]]) begin errors++; $display("FAIL rstmid_rdata got=%h exp=%h", rd, adc_val[req_ch[3*exp +: 3]]); end
    endtask

    initial begin
        for (int c = 0; c < 8; c++) adc_val[c] = 8'($urandom);
        test_reset();
        test_divider();
        test_single();
        test_contention();
        test_stuck();
        test_dropped();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
